// File: rtl/header_frame_rx_if.sv
// Receive-side bundle for header_frame_rx: UART byte stream in, validated header out.
interface header_frame_rx_if #(
  parameter int unsigned HEADER_BYTES = 80
);
  localparam int unsigned HDR_W = 8 * HEADER_BYTES;

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_error;
  logic [HDR_W-1:0] header;
  logic             header_valid;
  logic             header_ready;

  // Framer side: consumes the byte stream, publishes the header.
  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_error,
    input  header_ready,
    output header,
    output header_valid
  );

  // Environment side: drives the byte stream, takes the header.
  modport master (
    output rx_valid,
    output rx_data,
    output rx_error,
    output header_ready,
    input  header,
    input  header_valid
  );
endinterface

// File: rtl/header_frame_rx.sv
// Recovers SYNC + payload + XOR-checksum framed headers from a UART byte stream
// and publishes only fully validated headers through a valid/ready handshake.
module header_frame_rx #(
  parameter int unsigned HEADER_BYTES   = 80,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  header_frame_rx_if.slave    bus,
  output logic                busy_o,
  output logic                frame_ok_o,
  output logic                frame_err_o,
  output logic                overrun_o,
  output logic [7:0]          err_count_o
);

  localparam int unsigned HDR_W    = 8 * HEADER_BYTES;
  localparam int unsigned IDX_W    = 7;
  localparam int unsigned GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned OFF_W    = $clog2(HDR_W);
  localparam int unsigned LAST_IDX = HEADER_BYTES - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [HDR_W-1:0]   shadow_q, shadow_d;
  logic [HDR_W-1:0]   header_q, header_d;
  logic               hv_q, hv_d;
  logic               busy_q, busy_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               commit;
  logic               reject;
  logic               timeout;
  logic [OFF_W-1:0]   wr_off;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and output decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    gap_d       = gap_q;
    shadow_d    = shadow_q;
    header_d    = header_q;
    hv_d        = hv_q & ~bus.header_ready;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    commit      = 1'b0;
    reject      = 1'b0;
    timeout     = (gap_q == GAP_W'(TIMEOUT_CYCLES));
    wr_off      = OFF_W'((LAST_IDX - 32'(idx_q)) * 32'd8);

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          csum_d  = '0;
          gap_d   = '0;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_error) begin
          reject = 1'b1;
        end else if (bus.rx_valid) begin
          shadow_d[wr_off +: 8] = bus.rx_data;
          csum_d = csum_q ^ bus.rx_data;
          gap_d  = '0;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(LAST_IDX)) state_d = S_CHECK;
        end else if (timeout) begin
          reject = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_CHECK: begin
        if (bus.rx_error) begin
          reject = 1'b1;
        end else if (bus.rx_valid) begin
          gap_d = '0;
          if (bus.rx_data == csum_q) commit = 1'b1;
          else                       reject = 1'b1;
        end else if (timeout) begin
          reject = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit wins over a same-cycle handshake; only an untaken header counts as overrun.
    if (commit) begin
      header_d   = shadow_q;
      hv_d       = 1'b1;
      frame_ok_d = 1'b1;
      overrun_d  = hv_q & ~bus.header_ready;
      state_d    = S_IDLE;
    end

    if (reject) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      state_d = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      csum_q      <= '0;
      gap_q       <= '0;
      shadow_q    <= '0;
      header_q    <= '0;
      hv_q        <= 1'b0;
      busy_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      gap_q       <= gap_d;
      shadow_q    <= shadow_d;
      header_q    <= header_d;
      hv_q        <= hv_d;
      busy_q      <= busy_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.header       = header_q;
  assign bus.header_valid = hv_q;
  assign busy_o           = busy_q;
  assign frame_ok_o       = frame_ok_q;
  assign frame_err_o      = frame_err_q;
  assign overrun_o        = overrun_q;
  assign err_count_o      = err_cnt_q;

endmodule

// File: tb/tb_header_frame_rx.sv
// Directed bench for header_frame_rx: framing, checksum, timeout, overrun, reset, error counting.
module tb_header_frame_rx;

  localparam int unsigned HB   = 80;
  localparam int unsigned HW   = 8 * HB;
  localparam int unsigned TO   = 100;
  localparam logic [7:0]  SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, frame_ok, frame_err, overrun;
  logic [7:0] err_count;
  int         total = 0;
  int         bad   = 0;

  header_frame_rx_if #(.HEADER_BYTES(HB)) bus ();

  header_frame_rx #(
    .HEADER_BYTES  (HB),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .frame_ok_o (frame_ok),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  // Expected header: payload byte i = base + i, first byte at the MSBs.
  function automatic logic [HW-1:0] build_hdr(input logic [7:0] base);
    logic [HW-1:0] h;
    h = '0;
    for (int i = 0; i < HB; i++) h = {h[HW-9:0], base + 8'(i)};
    return h;
  endfunction

  function automatic logic [7:0] calc_csum(input logic [7:0] base);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < HB; i++) x = x ^ (base + 8'(i));
    return x;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_payload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] flip, input logic rdy);
    send_byte(SYNC);
    send_payload(base, HB);
    bus.header_ready = rdy;
    send_byte(calc_csum(base) ^ flip);
    bus.header_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_error = 1'b0; bus.header_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    total++; if (bus.header !== '0) begin bad++; $display("FAIL reset_header got=%h want=0", bus.header); end
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.header_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
    total++; if ({frame_ok, frame_err, overrun} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {frame_ok, frame_err, overrun}); end
  endtask

  task automatic test_bad_checksum;
    send_frame(8'h00, 8'h01, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badcs_err got=%b want=1", frame_err); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL badcs_errcnt got=%0d want=1", err_count); end
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL badcs_valid got=%b want=0", bus.header_valid); end
    total++; if (bus.header !== '0) begin bad++; $display("FAIL badcs_header got=%h want=0", bus.header); end
    total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL badcs_ok got=%b want=0", frame_ok); end
    idle(1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL badcs_err_pulse got=%b want=0", frame_err); end
  endtask

  task automatic test_good_frame;
    logic [HW-1:0] exp;
    exp = build_hdr(8'h00);
    send_byte(SYNC);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b want=1", busy); end
    send_payload(8'h00, HB);
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL good_early_valid got=%b want=0", bus.header_valid); end
    send_byte(8'h00);
    total++; if (bus.header_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b want=1", bus.header_valid); end
    total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL good_ok got=%b want=1", frame_ok); end
    total++; if (bus.header[639:632] !== 8'h00) begin bad++; $display("FAIL good_msb got=%h want=00", bus.header[639:632]); end
    total++; if (bus.header[7:0] !== 8'h4F) begin bad++; $display("FAIL good_lsb got=%h want=4f", bus.header[7:0]); end
    total++; if (bus.header !== exp) begin bad++; $display("FAIL good_header got=%h want=%h", bus.header, exp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_idle got=%b want=0", busy); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL good_errcnt got=%0d want=1", err_count); end
    idle(1);
    total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL good_ok_pulse got=%b want=0", frame_ok); end
    total++; if (bus.header_valid !== 1'b1) begin bad++; $display("FAIL good_hold got=%b want=1", bus.header_valid); end
    bus.header_ready = 1'b1;
    idle(1);
    bus.header_ready = 1'b0;
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL good_taken got=%b want=0", bus.header_valid); end
    total++; if (bus.header !== exp) begin bad++; $display("FAIL good_header_kept got=%h want=%h", bus.header, exp); end
  endtask

  task automatic test_timeout;
    int  seen;
    int  when;
    bit  got;
    send_byte(SYNC);
    send_payload(8'h00, 10);
    seen = 0;
    repeat (TO - 1) begin
      @(negedge clk);
      if (frame_err) seen++;
    end
    send_byte(8'h55);
    total++; if (seen !== 0) begin bad++; $display("FAIL gap99_err got=%0d want=0", seen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap99_busy got=%b want=1", busy); end
    got = 1'b0;
    when = 0;
    for (int c = 1; c <= 150 && !got; c++) begin
      @(negedge clk);
      if (frame_err) begin got = 1'b1; when = c; end
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL timeout_seen got=%b want=1", got); end
    total++; if (when < TO || when > TO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d..%0d", when, TO, TO + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL timeout_errcnt got=%0d want=2", err_count); end
  endtask

  task automatic test_overrun;
    send_frame(8'h10, 8'h00, 1'b0);
    total++; if (bus.header_valid !== 1'b1) begin bad++; $display("FAIL ovr_first_valid got=%b want=1", bus.header_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", overrun); end
    send_frame(8'h20, 8'h00, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
    total++; if (bus.header !== build_hdr(8'h20)) begin bad++; $display("FAIL ovr_header got=%h want=%h", bus.header, build_hdr(8'h20)); end
    total++; if (bus.header_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", bus.header_valid); end
    idle(1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pulse_len got=%b want=0", overrun); end
    send_frame(8'h30, 8'h00, 1'b1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_handshake got=%b want=0", overrun); end
    total++; if (bus.header_valid !== 1'b1) begin bad++; $display("FAIL ovr_hs_valid got=%b want=1", bus.header_valid); end
    total++; if (bus.header !== build_hdr(8'h30)) begin bad++; $display("FAIL ovr_hs_header got=%h want=%h", bus.header, build_hdr(8'h30)); end
    bus.header_ready = 1'b1;
    idle(1);
    bus.header_ready = 1'b0;
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", bus.header_valid); end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(SYNC);
    send_payload(8'h00, 40);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.header !== '0) begin bad++; $display("FAIL rstmid_header got=%h want=0", bus.header); end
    total++; if (bus.header_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.header_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rstmid_errcnt got=%0d want=0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h40, 8'h00, 1'b0);
    total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL rstmid_ok got=%b want=1", frame_ok); end
    total++; if (bus.header !== build_hdr(8'h40)) begin bad++; $display("FAIL rstmid_after got=%h want=%h", bus.header, build_hdr(8'h40)); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rstmid_errcnt2 got=%0d want=0", err_count); end
  endtask

  task automatic test_noise_rx_error;
    send_byte(8'h12);
    send_byte(8'h34);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL noise_busy got=%b want=0", busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL noise_err got=%b want=0", frame_err); end
    send_byte(SYNC);
    send_payload(8'h00, 20);
    bus.rx_error = 1'b1;
    @(negedge clk);
    bus.rx_error = 1'b0;
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL rxerr_err got=%b want=1", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rxerr_busy got=%b want=0", busy); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL rxerr_errcnt got=%0d want=1", err_count); end
    total++; if (bus.header !== build_hdr(8'h40) || bus.header_valid !== 1'b1) begin bad++; $display("FAIL rxerr_header_kept got=%h/%b want=%h/1", bus.header, bus.header_valid, build_hdr(8'h40)); end
    // Checksum byte equal to SYNC rejects and must not start a new frame.
    send_frame(8'h00, SYNC, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL syncrej_err got=%b want=1", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL syncrej_busy got=%b want=0", busy); end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL syncrej_errcnt got=%0d want=2", err_count); end
  endtask

  task automatic test_err_saturation;
    for (int i = 0; i < 260; i++) begin
      send_byte(SYNC);
      bus.rx_error = 1'b1;
      @(negedge clk);
      bus.rx_error = 1'b0;
      if (i == 9) begin
        total++; if (err_count !== 8'd12) begin bad++; $display("FAIL sat_mid got=%0d want=12", err_count); end
      end
    end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", err_count); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL sat_err_pulse got=%b want=1", frame_err); end
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_good_frame();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_noise_rx_error();
    test_err_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/header_frame_rx.md
Name: header_frame_rx

Overview:
- Sits between the UART receiver and the header shift register / hashing core.
- Consumes the receiver's byte strobe and byte and recovers framed 80-byte block headers of the form SYNC, 80 payload bytes, XOR checksum.
- Publishes a validated 640-bit header through a valid/ready handshake, so the hasher never sees a partial or corrupted header.
- Counts rejected frames for display and debug.

Parameters:
- HEADER_BYTES, 80, payload length in bytes; header width = 8*HEADER_BYTES.
- SYNC_BYTE, 8'hAA, frame start marker.
- TIMEOUT_CYCLES, 500000, maximum idle clocks between bytes inside a frame (10 ms at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz domain shared with the UART.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_error  in  1  UART framing error strobe.
- header  out  8*HEADER_BYTES  last accepted header; first payload byte at the MSBs [639:632].
- header_valid  out  1  accepted header pending.
- header_ready  in  1  consumer takes the header when header_valid && header_ready.
- busy  out  1  high in any state other than IDLE.
- frame_ok  out  1  one-cycle pulse when a frame commits.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- overrun  out  1  one-cycle pulse when an untaken header is overwritten.
- err_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; header = 0; header_valid, frame_ok, frame_err and overrun = 0; err_count = 0; all internal counters, the shadow buffer and the checksum are cleared. Reset mid-frame discards the partial frame.
- IDLE:
  - rx_valid with rx_data == SYNC_BYTE → PAYLOAD; byte index = 0; checksum = 0; gap timer = 0.
  - Any other byte is ignored; no error is raised.
- PAYLOAD:
  - Each rx_valid writes the byte into the shadow buffer at index (MSB-first), sets checksum ^= byte, increments the index and clears the gap timer.
  - When index reaches HEADER_BYTES-1 and that byte is accepted → CHECK.
  - SYNC_BYTE values inside the payload are treated as ordinary data.
- CHECK:
  - On the next rx_valid, the byte is compared with the checksum.
  - Match: on the following edge header ← shadow buffer, header_valid = 1, frame_ok pulses, state → IDLE. Latency is 1 clock from the checksum strobe to header_valid.
  - Mismatch → reject.
- Gap timer: counts clocks without rx_valid in PAYLOAD and CHECK. When it reaches TIMEOUT_CYCLES, the frame is rejected.
  - If rx_valid arrives on the same cycle the timer reaches the limit, the byte is accepted and the timer clears.
- rx_error in PAYLOAD or CHECK → reject. In IDLE it is ignored.
- Reject:
  - frame_err pulses for 1 cycle; err_count increments, saturating at 255; state → IDLE.
  - header and header_valid are unchanged.
  - A rejecting byte is not re-examined as SYNC.
- Handshake:
  - header_valid clears on the edge after header_valid && header_ready.
  - header stays stable while header_valid = 1, except on overwrite.
  - A commit while header_valid = 1 and header_ready = 0 overwrites header, keeps header_valid = 1 and pulses overrun.
  - A commit on the same cycle as a handshake: header_valid stays 1 with the new header; no overrun.
- Only the header output register is 640 bits wide, plus one 640-bit shadow buffer. The index counter is 7 bits wide; the gap timer is clog2(TIMEOUT_CYCLES+1) bits wide.

Test Plan:
- Good frame: AA, bytes 00..4F, checksum 0x00 (XOR of 0..79) → 1 clock after the checksum strobe: header[639:632] = 00, header[7:0] = 4F, header_valid = 1, frame_ok pulses once; header_ready = 1 for one cycle → header_valid = 0.
- Bad checksum: same frame with checksum 0x01 → frame_err pulses, err_count = 1, header_valid stays 0, header unchanged (all zero after reset).
- Timeout: AA + 10 bytes, then silence for TIMEOUT_CYCLES clocks (TIMEOUT_CYCLES = 100 in sim) → frame_err, IDLE, busy = 0. A 99-clock gap → no error.
- Overrun: two good frames with header_ready held 0 → second commit pulses overrun, header = second payload, header_valid = 1. Repeat with header_ready = 1 on the commit cycle → no overrun.
- Reset mid-frame: drive reset low after AA + 40 bytes → all outputs zero immediately (asynchronous); afterwards a full good frame is accepted normally.
- Noise/rx_error: bytes 12, 34 before AA are ignored; rx_error at payload byte 20 → frame_err. Driving 260 bad frames → err_count = 255.
